// File: rtl/regfile_scoreboard_if.sv
// Decode / writeback bundle for the register file scoreboard.
// master drives decode and writeback; slave is the scoreboard.
interface regfile_scoreboard_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            IssueValidD;
  logic [AW-1:0]   Rs1D;
  logic [AW-1:0]   Rs2D;
  logic            Rs1UsedD;
  logic            Rs2UsedD;
  logic [AW-1:0]   RdD;
  logic            RegWriteD;
  logic [XLEN-1:0] RD1D;
  logic [XLEN-1:0] RD2D;
  logic            StallD;
  logic            RegWriteW;
  logic [AW-1:0]   RdW;
  logic [XLEN-1:0] ResultW;
  logic            KillValid;
  logic [AW-1:0]   KillRd;
  logic            ScbErr;

  modport master (
    output IssueValidD, Rs1D, Rs2D, Rs1UsedD, Rs2UsedD,
    output RdD, RegWriteD, RegWriteW, RdW, ResultW,
    output KillValid, KillRd,
    input  RD1D, RD2D, StallD, ScbErr
  );

  modport slave (
    input  IssueValidD, Rs1D, Rs2D, Rs1UsedD, Rs2UsedD,
    input  RdD, RegWriteD, RegWriteW, RdW, ResultW,
    input  KillValid, KillRd,
    output RD1D, RD2D, StallD, ScbErr
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending counters and RAW/WAW stall.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback to decode.
module regfile_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst,
  regfile_scoreboard_if.slave bus
);
  localparam int AW  = $clog2(NREGS);
  localparam int SW  = CNT_W + 2;
  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [CNT_W-1:0] r_cnt  [NREGS];
  logic             r_err;

  logic             w_wb_en;
  logic             w_kill_en;
  logic             w_pend1;
  logic             w_pend2;
  logic             w_waw;
  logic             w_stall;
  logic             w_issue;
  logic             w_uflow;
  logic [SW-1:0]    w_sum   [NREGS];
  logic [CNT_W-1:0] w_nxt   [NREGS];

  assign w_wb_en   = bus.RegWriteW && (bus.RdW != '0);
  assign w_kill_en = bus.KillValid && (bus.KillRd != '0);

`ifdef REGFILE_BYPASS_EN
  logic w_fwd1;
  logic w_fwd2;
  assign w_fwd1  = w_wb_en && (bus.RdW == bus.Rs1D);
  assign w_fwd2  = w_wb_en && (bus.RdW == bus.Rs2D);
  // the last in-flight write retiring now is already forwarded
  assign w_pend1 = (r_cnt[bus.Rs1D] != '0) &&
                   !(w_fwd1 && r_cnt[bus.Rs1D] == ONE);
  assign w_pend2 = (r_cnt[bus.Rs2D] != '0) &&
                   !(w_fwd2 && r_cnt[bus.Rs2D] == ONE);
  assign bus.RD1D = w_fwd1 ? bus.ResultW : r_regs[bus.Rs1D];
  assign bus.RD2D = w_fwd2 ? bus.ResultW : r_regs[bus.Rs2D];
`else
  assign w_pend1  = (r_cnt[bus.Rs1D] != '0);
  assign w_pend2  = (r_cnt[bus.Rs2D] != '0);
  assign bus.RD1D = r_regs[bus.Rs1D];
  assign bus.RD2D = r_regs[bus.Rs2D];
`endif

  assign w_waw   = bus.RegWriteD && (bus.RdD != '0) &&
                   (r_cnt[bus.RdD] == MAX);
  assign w_stall = bus.IssueValidD &&
                   ((bus.Rs1UsedD && w_pend1) ||
                    (bus.Rs2UsedD && w_pend2) ||
                    w_waw);
  assign w_issue = bus.IssueValidD && !w_stall &&
                   bus.RegWriteD && (bus.RdD != '0);

  assign bus.StallD = w_stall;
  assign bus.ScbErr = r_err;

  // inc and both decs sum; a negative result clamps and flags
  always_comb begin
    w_uflow = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      w_sum[i] = SW'(r_cnt[i])
               + SW'(w_issue   && bus.RdD    == AW'(i))
               - SW'(w_wb_en   && bus.RdW    == AW'(i))
               - SW'(w_kill_en && bus.KillRd == AW'(i));
      w_nxt[i] = w_sum[i][CNT_W-1:0];
      if (w_sum[i][SW-1]) begin
        w_nxt[i] = '0;
        w_uflow  = 1'b1;
      end else if (|w_sum[i][SW-2:CNT_W]) begin
        w_nxt[i] = MAX;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_err <= 1'b0;
    end else begin
      if (w_wb_en) r_regs[bus.RdW] <= bus.ResultW;
      for (int i = 0; i < NREGS; i++) r_cnt[i] <= w_nxt[i];
      r_err <= r_err | w_uflow;
    end
  end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Decode-side register file and hazard scoreboard: the consumer end of the writeback result path.
- Takes the writeback write port (RegWriteW, RdW, ResultW) and serves two read ports to decode.
- Tracks in-flight destination registers with per-register pending counters and raises StallD on RAW or WAW-limit hazards.
- Sits between decode_cycle and writeback_cycle in the 5-stage pipeline.

Parameters:
- XLEN, 32, data width.
- NREGS, 32, number of architectural registers; index width is log2(NREGS).
- CNT_W, 2, pending-counter width; maximum writes in flight per register is 2^CNT_W-1.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset; asynchronous, active-low.
- IssueValidD  input  1  decode presents an instruction this cycle.
- Rs1D  input  5  source 1 index.
- Rs2D  input  5  source 2 index.
- Rs1UsedD  input  1  instruction reads Rs1D.
- Rs2UsedD  input  1  instruction reads Rs2D.
- RdD  input  5  destination index.
- RegWriteD  input  1  instruction writes RdD.
- RD1D  output  XLEN  read data for Rs1D.
- RD2D  output  XLEN  read data for Rs2D.
- StallD  output  1  hold decode; the instruction is not issued.
- RegWriteW  input  1  writeback writes RdW.
- RdW  input  5  writeback destination.
- ResultW  input  XLEN  writeback data.
- KillValid  input  1  a flushed instruction that would have written KillRd.
- KillRd  input  5  destination of the killed instruction.
- ScbErr  output  1  sticky error flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - All registers are 0.
  - All counters are 0.
  - ScbErr=0.
  - StallD=0, because it is combinational and IssueValidD is expected low during reset.
- x0:
  - Reads always return 0.
  - Writes to x0 are ignored.
  - x0 is never tracked: its counter stays 0 and it never causes a stall.
- Reads: combinational from the array. A same-cycle WB write is visible on reads only in the next cycle, unless BYPASS_EN is defined.
- Write: on a clock edge with RegWriteW && RdW!=0, reg[RdW] <= ResultW.
- pending(r) is true when cnt[r] != 0.
- StallD = IssueValidD && (A || B || C):
  - A: Rs1UsedD && pending(Rs1D).
  - B: Rs2UsedD && pending(Rs2D).
  - C: RegWriteD && RdD!=0 && cnt[RdD] == max. This is the WAW limit.
- Issue accepted: IssueValidD && !StallD && RegWriteD && RdD!=0 gives inc on RdD.
- Retire: RegWriteW && RdW!=0 gives dec on RdW.
- Kill: KillValid && KillRd!=0 gives dec on KillRd.
- Per-register next count is cnt + inc - decs. inc, WB dec and kill dec can all hit the same register in one cycle and are summed. All three simultaneous on one register nets -1.
- Underflow (net decrement below 0):
  - The counter clamps at 0.
  - ScbErr is set and held until reset.
- Overflow is impossible, because of stall condition C.
- Latency:
  - Register data written at edge N is readable combinationally after edge N.
  - A stall clears in the cycle after the retiring WB edge (or the same cycle with BYPASS_EN).
- Mid-operation reset clears all pending state immediately. Upstream pipeline registers are reset at the same time.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- When defined:
  - If RegWriteW && RdW!=0 && RdW==Rs1D, then RD1D=ResultW. RD2D is handled likewise.
  - For hazard checks A and B, a source whose cnt==1 and is being retired this cycle (WB only, not Kill) is treated as not pending.
- When undefined: no forwarding, and such reads stall one extra cycle.

Test Plan:
- Reset, then read x5 with no writes → RD1D=0, StallD=0, ScbErr=0. Write x0=0xDEADBEEF via WB → a later read of x0 returns 0.
- Issue RdD=3, RegWriteD=1. Next cycle issue Rs1D=3, Rs1UsedD=1 → StallD=1. Then WB RdW=3, ResultW=0x1234:
  - Without bypass: StallD falls the cycle after that edge and RD1D=0x1234.
  - With bypass: StallD=0 and RD1D=0x1234 in the WB cycle.
- Issue writes to x7 three times back to back (cnt=3), then a fourth → StallD=1 via condition C. One WB to x7 → the fourth issues and cnt returns to 3.
- Issue x9 (cnt=1), then KillValid with KillRd=9 → cnt=0. A reader of x9 does not stall. ScbErr stays 0.
- Same cycle: issue to x4 accepted, WB to x4, and kill of x4, starting from cnt=2 → cnt=1.
- WB to x6 with cnt=0 → ScbErr=1 and stays 1 until rst=0. Asserting rst mid-stall → StallD drops and all counters are 0.
